// File: rtl/hex_scroll_pkg.sv
// Shared definitions for the scrolling hex display: FSM states and glyphs.
package hex_scroll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Active-low 7-segment glyphs for 0-F, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg.sv
// 4-bit digit to active-low 7-segment glyph.
module hex7seg
  import hex_scroll_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup of the glyph.
  always_comb begin
    seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolls a 16-digit hex message across six displays with run/pause,
// single-step, in-place digit edit and direction control.
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int unsigned TICK_BASE = 5_000_000,
  parameter logic [63:0] MSG       = 64'h0123456789ABCDEF
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [3:1] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  localparam int unsigned CNT_W = $clog2(TICK_BASE * 16);

  state_e            state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic              dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [0:15][3:0]  store_q, store_d;
  logic [3:1]        ks1_q, ks1_d, ks2_q, ks2_d, ks3_q, ks3_d;
  logic [3:1]        press;
  logic              tick;
  logic [31:0]       limit;
  logic [3:0]        step_ptr;
  logic [6:0]        seg [6];
  logic              unused_sw;

  assign unused_sw = SW[8];

  // Two-flop synchroniser plus one history flop; press = synchronised 1 -> 0.
  always_comb begin
    ks1_d = KEY;
    ks2_d = ks1_q;
    ks3_d = ks2_q;
    press = ks3_q & ~ks2_q;
  end

  // Rate prescaler: counts only in RUN; a count already past a lowered
  // limit fires immediately and restarts.
  always_comb begin
    limit = (32'(SW[3:0]) + 32'd1) * TICK_BASE;
    tick  = 1'b0;
    cnt_d = '0;
    if (state_q == RUN) begin
      if (32'(cnt_q) + 32'd1 >= limit) begin
        tick = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic: FSM, pointer stepping, direction and digit edit.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    dir_d    = dir_q;
    store_d  = store_q;
    step_ptr = dir_q ? ptr_q - 4'd1 : ptr_q + 4'd1;
    if (press[3]) dir_d = ~dir_q;
    if (tick) ptr_d = step_ptr;
    case (state_q)
      IDLE:    if (press[1]) state_d = RUN;
      RUN:     if (press[1]) state_d = PAUSE;
      PAUSE: begin
        if (press[1]) begin
          state_d = RUN;
        end else if (press[2]) begin
          if (SW[9]) store_d[ptr_q] = SW[7:4];
          else       ptr_d = step_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      store_q <= MSG;
      ks1_q   <= '1;
      ks2_q   <= '1;
      ks3_q   <= '1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      ks1_q   <= ks1_d;
      ks2_q   <= ks2_d;
      ks3_q   <= ks3_d;
    end
  end

  // Six decoders showing digits ptr .. ptr+5; seg[0] is the leftmost display.
  for (genvar k = 0; k < 6; k++) begin : g_digit
    logic [3:0] idx;
    assign idx = ptr_q + 4'(k);
    hex7seg u_seg (
      .digit (store_q[idx]),
      .seg   (seg[k])
    );
  end

  assign HEX5 = seg[0];
  assign HEX4 = seg[1];
  assign HEX3 = seg[2];
  assign HEX2 = seg[3];
  assign HEX1 = seg[4];
  assign HEX0 = seg[5];

  assign LEDR = {2'b00, ptr_q, tick, dir_q, state_q == PAUSE, state_q == RUN};

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed self-checking bench for hex_scroll_ctrl with TICK_BASE = 4.
module tb_hex_scroll_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b1;
  logic [3:1] KEY      = 3'b111;
  logic [9:0] SW       = '0;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;
  logic [41:0] hv;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [41:0] RESET_HEX = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

  always #10 CLOCK_50 = ~CLOCK_50;

  assign hv = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  hex_scroll_ctrl #(.TICK_BASE(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .KEY      (KEY),
    .SW       (SW),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .LEDR     (LEDR)
  );

  task automatic do_reset();
    KEY = 3'b111;
    SW  = '0;
    @(negedge CLOCK_50);
    Resetn = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    Resetn = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic press_key(input int b);
    @(negedge CLOCK_50);
    KEY[b] = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    KEY[b] = 1'b1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!LEDR[3] && n < 200);
    n_checks++;
    if (LEDR[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_timeout: got tick=%b after %0d cycles, required 1", LEDR[3], n);
    end
  endtask

  task automatic test_reset();
    #1 Resetn = 1'b0;
    #2;
    n_checks++;
    if (LEDR !== 10'd0) begin n_fail++; $display("FAIL reset_async_ledr: got %h required %h", LEDR, 10'd0); end
    n_checks++;
    if (hv !== RESET_HEX) begin n_fail++; $display("FAIL reset_async_hex: got %h required %h", hv, RESET_HEX); end
    repeat (2) @(negedge CLOCK_50);
    Resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    n_checks++;
    if (LEDR !== 10'd0) begin n_fail++; $display("FAIL reset_ledr: got %h required %h", LEDR, 10'd0); end
    n_checks++;
    if (hv !== RESET_HEX) begin n_fail++; $display("FAIL reset_hex: got %h required %h", hv, RESET_HEX); end
    press_key(2);
    repeat (2) @(negedge CLOCK_50);
    n_checks++;
    if (LEDR !== 10'd0) begin n_fail++; $display("FAIL idle_key2_ignored: got %h required %h", LEDR, 10'd0); end
  endtask

  task automatic test_forward_wrap();
    int n;
    do_reset();
    @(negedge CLOCK_50);
    KEY[1] = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    KEY[1] = 1'b1;
    n_checks++;
    if (LEDR[1:0] !== 2'b01) begin n_fail++; $display("FAIL fwd_run_state: got %b required %b", LEDR[1:0], 2'b01); end
    for (int t = 1; t <= 16; t++) begin
      wait_tick(n);
      n_checks++;
      if (n !== ((t == 1) ? 2 : 4)) begin
        n_fail++;
        $display("FAIL fwd_tick_spacing: tick %0d after %0d cycles, required %0d", t, n, (t == 1) ? 2 : 4);
      end
      @(posedge CLOCK_50);
      #1;
      n_checks++;
      if (LEDR[7:4] !== 4'(t)) begin n_fail++; $display("FAIL fwd_ptr: tick %0d got ptr %0d required %0d", t, LEDR[7:4], 4'(t)); end
      if (t == 11) begin
        n_checks++;
        if (hv !== {7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40}) begin
          n_fail++;
          $display("FAIL fwd_hex_ptr11: got %h required %h", hv, {7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40});
        end
      end
    end
  endtask

  task automatic test_reverse_wrap();
    int n;
    do_reset();
    press_key(3);
    n_checks++;
    if (LEDR !== 10'b00_0000_0100) begin n_fail++; $display("FAIL rev_dir_idle: got %b required %b", LEDR, 10'b00_0000_0100); end
    press_key(1);
    wait_tick(n);
    @(posedge CLOCK_50);
    #1;
    n_checks++;
    if (LEDR[7:4] !== 4'd15) begin n_fail++; $display("FAIL rev_ptr: got %0d required 15", LEDR[7:4]); end
    n_checks++;
    if ({HEX5, HEX4} !== {7'h0E, 7'h40}) begin n_fail++; $display("FAIL rev_hex: got %h required %h", {HEX5, HEX4}, {7'h0E, 7'h40}); end
  endtask

  task automatic test_pause_step_edit();
    int n;
    int seen;
    do_reset();
    press_key(1);
    wait_tick(n);
    wait_tick(n);
    KEY[1] = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    KEY[1] = 1'b1;
    n_checks++;
    if ({LEDR[7:4], LEDR[1:0]} !== {4'd2, 2'b10}) begin
      n_fail++;
      $display("FAIL pause_entry: got ptr %0d state %b required ptr 2 state 10", LEDR[7:4], LEDR[1:0]);
    end
    seen = 0;
    repeat (20) begin
      @(negedge CLOCK_50);
      if (LEDR[3]) seen++;
    end
    n_checks++;
    if (seen != 0 || LEDR[7:4] !== 4'd2) begin
      n_fail++;
      $display("FAIL pause_no_tick: got %0d ticks ptr %0d required 0 ticks ptr 2", seen, LEDR[7:4]);
    end
    press_key(2);
    n_checks++;
    if (LEDR[7:4] !== 4'd3) begin n_fail++; $display("FAIL pause_step: got ptr %0d required 3", LEDR[7:4]); end
    SW[9]   = 1'b1;
    SW[7:4] = 4'd7;
    press_key(2);
    n_checks++;
    if ({HEX5, HEX4, LEDR[7:4]} !== {7'h78, 7'h19, 4'd3}) begin
      n_fail++;
      $display("FAIL pause_edit: got %h/%h ptr %0d required 78/19 ptr 3", HEX5, HEX4, LEDR[7:4]);
    end
  endtask

  task automatic test_coincide();
    SW[9] = 1'b0;
    @(negedge CLOCK_50);
    KEY[1] = 1'b0;
    KEY[2] = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    n_checks++;
    if ({LEDR[7:4], LEDR[1:0]} !== {4'd3, 2'b01}) begin
      n_fail++;
      $display("FAIL coincide: got ptr %0d state %b required ptr 3 state 01", LEDR[7:4], LEDR[1:0]);
    end
    n_checks++;
    if (HEX5 !== 7'h78) begin n_fail++; $display("FAIL coincide_no_write: got %h required %h", HEX5, 7'h78); end
    @(negedge CLOCK_50);
    KEY = 3'b111;
  endtask

  task automatic test_rate_drop();
    int n;
    do_reset();
    SW[3:0] = 4'd3;
    press_key(1);
    wait_tick(n);
    wait_tick(n);
    n_checks++;
    if (n != 16) begin n_fail++; $display("FAIL rate3_spacing: got %0d cycles required 16", n); end
    repeat (10) @(negedge CLOCK_50);
    SW[3:0] = 4'd0;
    #1;
    n_checks++;
    if (LEDR[3] !== 1'b1) begin n_fail++; $display("FAIL rate_drop_tick: got %b required 1", LEDR[3]); end
    @(posedge CLOCK_50);
    #1;
    n_checks++;
    if (LEDR[7:4] !== 4'd3) begin n_fail++; $display("FAIL rate_drop_ptr: got %0d required 3", LEDR[7:4]); end
    wait_tick(n);
    n_checks++;
    if (n != 4) begin n_fail++; $display("FAIL rate_drop_restart: got %0d cycles required 4", n); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    do_reset();
    press_key(1);
    wait_tick(n);
    KEY[1] = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    KEY[1] = 1'b1;
    SW[9]   = 1'b1;
    SW[7:4] = 4'hA;
    press_key(2);
    n_checks++;
    if ({HEX5, LEDR[7:4]} !== {7'h08, 4'd1}) begin
      n_fail++;
      $display("FAIL midrun_edit: got %h ptr %0d required 08 ptr 1", HEX5, LEDR[7:4]);
    end
    SW[9] = 1'b0;
    press_key(1);
    repeat (5) wait_tick(n);
    @(negedge CLOCK_50);
    #3 Resetn = 1'b0;
    #1;
    n_checks++;
    if (LEDR !== 10'd0) begin n_fail++; $display("FAIL midrun_reset_ledr: got %h required %h", LEDR, 10'd0); end
    n_checks++;
    if (hv !== RESET_HEX) begin n_fail++; $display("FAIL midrun_reset_hex: got %h required %h", hv, RESET_HEX); end
    Resetn = 1'b1;
    repeat (8) @(negedge CLOCK_50);
    n_checks++;
    if (LEDR !== 10'd0 || hv !== RESET_HEX) begin
      n_fail++;
      $display("FAIL midrun_after_reset: got ledr %h hex %h required 0 / %h", LEDR, hv, RESET_HEX);
    end
  endtask

  initial begin
    test_reset();
    test_forward_wrap();
    test_reverse_wrap();
    test_pause_step_edit();
    test_coincide();
    test_rate_drop();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_scroll_ctrl.md
HEX_SCROLL_CTRL -- requirements
Module: hex_scroll_ctrl

Interface
REQ-001 SHALL have parameter TICK_BASE, default 5_000_000, meaning CLOCK_50 cycles per rate unit (0.1 s).
REQ-002 SHALL have parameter MSG, default 64'h0123456789ABCDEF, meaning the reset message; digit i = MSG[63-4i -: 4], i = 0..15.
REQ-003 SHALL have port CLOCK_50  input  1  meaning the single clock, rising edge.
REQ-004 SHALL have port Resetn  input  1  meaning the reset; it is asynchronous and active-low.
REQ-005 SHALL have port KEY  input  3 [3:1]  meaning raw active-low pushbuttons: [1] run/pause, [2] step/write, [3] direction toggle.
REQ-006 SHALL have port SW  input  10  meaning [3:0] rate, [7:4] edit digit, [9] edit enable, [8] unused.
REQ-007 SHALL have ports HEX0..HEX5  output  7 each  meaning active-low segments, bit 6 = g down to bit 0 = a.
REQ-008 SHALL have port LEDR  output  10  meaning status.

Function
REQ-009 SHALL pass each KEY bit through a two-flop synchroniser, then detect a press as synchronised 1 -> 0; the press acts on the 3rd rising edge after the pin falls.
REQ-010 SHALL hold a 16 x 4-bit message store, a 4-bit pointer ptr, a direction bit dir (0 = forward) and states IDLE, RUN, PAUSE.
REQ-011 SHALL transition IDLE -KEY1-> RUN, RUN -KEY1-> PAUSE, PAUSE -KEY1-> RUN; there are no other transitions except reset.
REQ-012 SHALL, in RUN only, run a prescaler that fires a one-cycle tick every (SW[3:0]+1)*TICK_BASE cycles; the prescaler is cleared on entry to RUN and held at 0 outside RUN.
REQ-013 SHALL, if SW[3:0] drops so the count is at or above the new limit, fire the tick on the next cycle and restart the count.
REQ-014 SHALL, on a tick, set ptr to ptr+1 when dir = 0 and ptr-1 when dir = 1, modulo 16 (15 -> 0 forward, 0 -> 15 reverse).
REQ-015 SHALL, on a KEY3 press in any state, toggle dir; a tick in the same cycle uses the old dir.
REQ-016 SHALL, on a KEY2 press in PAUSE with SW[9] = 0, step ptr once per REQ-014.
REQ-017 SHALL, on a KEY2 press in PAUSE with SW[9] = 1, write SW[7:4] into digit ptr and leave ptr unchanged.
REQ-018 SHALL ignore KEY2 in IDLE and RUN.
REQ-019 SHALL, when KEY1 and KEY2 presses coincide, apply KEY1 only.
REQ-020 SHALL drive HEX5, HEX4, HEX3, HEX2, HEX1, HEX0 as the decode of digits ptr, ptr+1, ..., ptr+5 (mod 16), combinationally from registered state.
REQ-021 SHALL decode 0-F to the standard DE-series glyphs (0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 7 = 7'h78, F = 7'h0E).
REQ-022 SHALL drive LEDR[0] = RUN, LEDR[1] = PAUSE, LEDR[2] = dir, LEDR[3] = tick, LEDR[7:4] = ptr, LEDR[9:8] = 0.

Reset
REQ-023 SHALL, while Resetn = 0, force state IDLE, ptr 0, dir 0, prescaler 0, synchronisers to 1, and store = MSG, independent of CLOCK_50.
REQ-024 SHALL, for the default MSG at reset, show HEX5..HEX0 = 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12 and LEDR = 0.
REQ-025 SHALL, when reset is asserted mid-RUN, abandon any pending tick or press and restore MSG, discarding edits.

Structure
REQ-026 SHALL place the state encoding and the 16-entry segment glyph table in a shared package hex_scroll_pkg.
REQ-027 SHALL contain one sub-module, hex7seg (4-bit digit -> 7-bit active-low segments), instantiated six times.
REQ-028 SHALL size the prescaler from TICK_BASE*16 via $clog2.

Verification (TICK_BASE = 4)
REQ-029 SHALL check the reset scenario: Resetn low then high -> HEX5..HEX0 read 0,1,2,3,4,5, LEDR = 0.
REQ-030 SHALL check forward wrap: SW[3:0] = 0, press KEY1 -> tick every 4 cycles; after 11 ticks ptr = 11, HEX5..HEX0 read B,C,D,E,F,0; after 16 ticks ptr = 0.
REQ-031 SHALL check reverse wrap: in IDLE press KEY3, then KEY1 -> first tick gives ptr = 15, HEX5 = F (7'h0E), HEX4 = 0.
REQ-032 SHALL check pause/step/edit: run to ptr = 2, press KEY1 -> PAUSE, no ticks; KEY2 -> ptr = 3; SW[9] = 1, SW[7:4] = 7, KEY2 -> HEX5 = 7'h78, ptr = 3.
REQ-033 SHALL check coinciding presses: in PAUSE, KEY1 and KEY2 fall in the same cycle -> RUN, ptr unchanged.
REQ-034 SHALL check reset mid-run: after an edit and 5 ticks, pulse Resetn low for 1 ns off-edge -> immediate IDLE, ptr 0, original MSG glyphs.
